// File: rtl/asy_fifo.sv
// asy_fifo: single-clock 8 x 4 FIFO whose pops are paced by the asynchronous Rd_clk level.
// Define ASY_FIFO_DROP_FLAG_EN to add the sticky Wr_Drop output (write suppressed while full).
module asy_fifo #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  Wr_clk,
    input  logic                  reset,
    input  logic                  Rd_clk,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Wr_Full,
`ifdef ASY_FIFO_DROP_FLAG_EN
    output logic                  Wr_Drop,
`endif
    output logic                  Rd_Empty
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [SYNC_STAGES-1:0] sync;
    logic                   synced_d;
    logic                   rd_stb;
    logic                   do_wr;
    logic                   do_rd;

    // Flags decode the registered pointers; the extra MSB separates full from empty.
    always_comb begin
        Rd_Empty = (wptr == rptr);
        Wr_Full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
        rd_stb   = sync[SYNC_STAGES-1] & ~synced_d;
        do_wr    = ~Wr_Full;
        do_rd    = rd_stb & ~Rd_Empty;
    end

    // Rd_clk synchroniser, edge detector, pointers and read data register.
    always_ff @(posedge Wr_clk) begin
        if (reset) begin
            sync     <= '0;
            synced_d <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            Data_out <= '0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], Rd_clk};
            synced_d <= sync[SYNC_STAGES-1];
            if (do_wr) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_rd) begin
                Data_out <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr     <= rptr + PTR_W'(1);
            end
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge Wr_clk) begin
        if (!reset && do_wr) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= Data_in;
        end
    end

`ifdef ASY_FIFO_DROP_FLAG_EN
    // Sticky record of any write lost because the FIFO was full.
    always_ff @(posedge Wr_clk) begin
        if (reset) begin
            Wr_Drop <= 1'b0;
        end else if (Wr_Full) begin
            Wr_Drop <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_asy_fifo.sv
// tb_asy_fifo: drives asy_fifo with directed and random traffic and compares it cycle by cycle
// against a queue-based model of the FIFO and a sample history of the Rd_clk pacing level.
module tb_asy_fifo;

    localparam int unsigned SYNC = 2;

    logic       Wr_clk = 1'b0;
    logic       reset;
    logic       Rd_clk;
    logic [3:0] Data_in;
    logic [3:0] Data_out;
    logic       Wr_Full;
    logic       Rd_Empty;
`ifdef ASY_FIFO_DROP_FLAG_EN
    logic       Wr_Drop;
`endif

    asy_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .SYNC_STAGES(SYNC)) dut (
        .Wr_clk   (Wr_clk),
        .reset    (reset),
        .Rd_clk   (Rd_clk),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .Wr_Full  (Wr_Full),
`ifdef ASY_FIFO_DROP_FLAG_EN
        .Wr_Drop  (Wr_Drop),
`endif
        .Rd_Empty (Rd_Empty)
    );

    always #5 Wr_clk = ~Wr_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents queue, last popped value, drop flag, Rd_clk samples per edge.
    logic [3:0] mq[$];
    logic [3:0] m_dout = 4'h0;
    bit         m_drop = 1'b0;
    bit         rhist[$];
    int         m_pops = 0;

    // A pop is requested SYNC edges after the edge that first samples Rd_clk high.
    task automatic model_edge(input logic [3:0] din, input logic rc, input logic rst);
        bit stb;
        bit full;
        bit empty;
        if (rst) begin
            mq.delete();
            m_dout = 4'h0;
            m_drop = 1'b0;
            rhist.delete();
            for (int k = 0; k <= int'(SYNC); k++) rhist.push_back(1'b0);
        end else begin
            stb   = rhist[1] & ~rhist[0];
            full  = (mq.size() == 8);
            empty = (mq.size() == 0);
            if (stb && !empty) begin
                m_dout = mq.pop_front();
                m_pops++;
            end
            if (full) m_drop = 1'b1;
            else      mq.push_back(din);
            rhist.push_back(rc);
            void'(rhist.pop_front());
        end
    endtask

    task automatic step(input logic [3:0] din, input logic rc, input logic rst);
        Data_in = din;
        Rd_clk  = rc;
        reset   = rst;
        @(posedge Wr_clk);
        model_edge(din, rc, rst);
        #1;
    endtask

    task automatic test_reset();
        step(4'h5, 1'b0, 1'b1);
        step(4'h5, 1'b0, 1'b1);
        n_tests++;
        if (Data_out !== 4'h0) begin
            n_fail++; $display("FAIL reset_dout: got %h want 0", Data_out);
        end
        n_tests++;
        if (Rd_Empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_empty: got %b want 1", Rd_Empty);
        end
        n_tests++;
        if (Wr_Full !== 1'b0) begin
            n_fail++; $display("FAIL reset_full: got %b want 0", Wr_Full);
        end
`ifdef ASY_FIFO_DROP_FLAG_EN
        n_tests++;
        if (Wr_Drop !== 1'b0) begin
            n_fail++; $display("FAIL reset_drop: got %b want 0", Wr_Drop);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < 12; i++) begin
            step(4'(i), 1'b0, 1'b0);
            n_tests++;
            if (Rd_Empty !== 1'b0) begin
                n_fail++; $display("FAIL fill_empty[%0d]: got %b want 0", i, Rd_Empty);
            end
            n_tests++;
            if (Wr_Full !== (i >= 7)) begin
                n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, Wr_Full, i >= 7);
            end
        end
`ifdef ASY_FIFO_DROP_FLAG_EN
        n_tests++;
        if (Wr_Drop !== 1'b1) begin
            n_fail++; $display("FAIL fill_drop: got %b want 1", Wr_Drop);
        end
`endif
    endtask

    task automatic test_drain();
        int pops0;
        logic [3:0] last;
        pops0 = m_pops;
        last  = 4'hf;
        for (int j = 0; j < 24; j++) begin
            step(4'(8 + j), (j % 2 == 0), 1'b0);
            n_tests++;
            if (Data_out !== m_dout || Wr_Full !== (mq.size() == 8) ||
                Rd_Empty !== (mq.size() == 0)) begin
                n_fail++;
                $display("FAIL drain[%0d]: dout/full/empty got %h/%b/%b want %h/%b/%b", j,
                         Data_out, Wr_Full, Rd_Empty, m_dout, mq.size() == 8, mq.size() == 0);
            end
            // First eight pops must be the values written during fill, in order.
            if (m_pops - pops0 <= 8 && m_pops != pops0 && m_dout != last) begin
                n_tests++;
                if (Data_out !== 4'(m_pops - pops0 - 1)) begin
                    n_fail++;
                    $display("FAIL drain_order: got %h want %h", Data_out, 4'(m_pops - pops0 - 1));
                end
                last = m_dout;
            end
        end
    endtask

    task automatic test_rate_mismatch();
        step(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            step(4'(i % 16), (i % 2 == 1), 1'b0);
            n_tests++;
            if (Data_out !== m_dout || Wr_Full !== (mq.size() == 8) ||
                Rd_Empty !== (mq.size() == 0)) begin
                n_fail++;
                $display("FAIL rate[%0d]: dout/full/empty got %h/%b/%b want %h/%b/%b", i,
                         Data_out, Wr_Full, Rd_Empty, m_dout, mq.size() == 8, mq.size() == 0);
            end
        end
    endtask

    task automatic test_empty_read();
        step(4'h9, 1'b1, 1'b1);
        step(4'h9, 1'b1, 1'b0);
        n_tests++;
        if (Data_out !== 4'h0 || Rd_Empty !== 1'b0 || Wr_Full !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_read: dout/empty/full got %h/%b/%b want 0/0/0",
                     Data_out, Rd_Empty, Wr_Full);
        end
        for (int i = 0; i < 4; i++) begin
            step(4'h9, 1'b1, 1'b0);
            n_tests++;
            if (Data_out !== m_dout || Rd_Empty !== (mq.size() == 0)) begin
                n_fail++;
                $display("FAIL empty_read_follow[%0d]: dout/empty got %h/%b want %h/%b", i,
                         Data_out, Rd_Empty, m_dout, mq.size() == 0);
            end
        end
    endtask

    task automatic test_mid_reset();
        step(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(4'(3 + i), 1'b0, 1'b0);
        step(4'hc, 1'b1, 1'b1);
        n_tests++;
        if (Rd_Empty !== 1'b1 || Wr_Full !== 1'b0 || Data_out !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset: empty/full/dout got %b/%b/%h want 1/0/0",
                     Rd_Empty, Wr_Full, Data_out);
        end
        step(4'hc, 1'b0, 1'b0);
        n_tests++;
        if (Rd_Empty !== 1'b0 || Wr_Full !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_after: empty/full got %b/%b want 0/0", Rd_Empty, Wr_Full);
        end
    endtask

    task automatic test_random();
        logic rc;
        logic rst;
        rc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) rc = ~rc;
            rst = ($urandom_range(0, 79) == 0);
            step(4'($urandom), rc, rst);
            n_tests++;
            if (Data_out !== m_dout || Wr_Full !== (mq.size() == 8) ||
                Rd_Empty !== (mq.size() == 0)) begin
                n_fail++;
                $display("FAIL random[%0d]: dout/full/empty got %h/%b/%b want %h/%b/%b", i,
                         Data_out, Wr_Full, Rd_Empty, m_dout, mq.size() == 8, mq.size() == 0);
            end
`ifdef ASY_FIFO_DROP_FLAG_EN
            n_tests++;
            if (Wr_Drop !== m_drop) begin
                n_fail++; $display("FAIL random_drop[%0d]: got %b want %b", i, Wr_Drop, m_drop);
            end
`endif
        end
    endtask

    initial begin
        reset   = 1'b1;
        Rd_clk  = 1'b0;
        Data_in = 4'h0;
        test_reset();
        test_fill();
        test_drain();
        test_rate_mismatch();
        test_empty_read();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
